// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx among NUM_REQ byte-stream requesters.
// Each grant sends an optional channel header, then up to MAX_BURST bytes of one packet.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_BURST   = 16,
    parameter int HEADER_EN   = 1,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 grant_valid,
    output logic [3:0]           grant_id,
    output logic                 pkt_done,
    output logic                 err_timeout
);
    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(MAX_BURST + 1);
    localparam int AW  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HEADER    = 3'd1,
        S_DATA      = 3'd2,
        S_WAIT_ACK  = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    state_t          state_r;
    state_t          done_state_s;
    logic [IDW-1:0]  ptr_r;
    logic [IDW-1:0]  grant_idx_r;
    logic [IDW-1:0]  ptr_next_s;
    logic [IDW-1:0]  pick_idx_s;
    logic            pick_found_s;
    logic [CW-1:0]   count_r;
    logic [AW-1:0]   ack_cnt_r;
    logic            hdr_r;
    logic            last_r;
    logic            tx_start_r;
    logic [7:0]      tx_data_r;
    logic            grant_valid_r;
    logic            pkt_done_r;
    logic            err_timeout_r;
    logic            sel_valid_s;
    logic            sel_last_s;
    logic [7:0]      sel_data_s;
    logic            xfer_s;

    assign sel_valid_s = req_valid[grant_idx_r];
    assign sel_last_s  = req_last[grant_idx_r];
    assign sel_data_s  = req_data[{grant_idx_r, 3'b000} +: 8];
    assign xfer_s      = (state_r == S_DATA) && !tx_busy && sel_valid_s;
    assign ptr_next_s  = (grant_idx_r == IDW'(NUM_REQ - 1)) ? '0 : grant_idx_r + 1'b1;

    assign tx_start    = tx_start_r;
    assign tx_data     = tx_data_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = 4'(grant_idx_r);
    assign pkt_done    = pkt_done_r;
    assign err_timeout = err_timeout_r;

    // Round-robin pick: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int             cand;
        logic [IDW-1:0] cand_idx;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = 0;
        cand_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand     = int'(ptr_r) + k;
            cand     = (cand >= NUM_REQ) ? cand - NUM_REQ : cand;
            cand_idx = IDW'(cand);
            if (!pick_found_s && req_valid[cand_idx]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_idx;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Only the granted requester may see ready, and only while uart_tx is idle.
    always_comb begin
        req_ready = '0;
        if ((state_r == S_DATA) && !tx_busy) begin
            req_ready[grant_idx_r] = 1'b1;
        end else begin
            req_ready = '0;
        end
    end

    // Where to go once a byte has left uart_tx (or timed out).
    always_comb begin
        done_state_s = S_DATA;
        if (hdr_r) begin
            done_state_s = S_DATA;
        end else if (last_r || (count_r == CW'(MAX_BURST))) begin
            done_state_s = S_RELEASE;
        end else begin
            done_state_s = S_DATA;
        end
    end

    // Grant FSM with registered uart handshake and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            ptr_r         <= '0;
            grant_idx_r   <= '0;
            count_r       <= '0;
            ack_cnt_r     <= '0;
            hdr_r         <= 1'b0;
            last_r        <= 1'b0;
            tx_start_r    <= 1'b0;
            tx_data_r     <= 8'h00;
            grant_valid_r <= 1'b0;
            pkt_done_r    <= 1'b0;
            err_timeout_r <= 1'b0;
        end else begin
            // tx_start and pkt_done are single-cycle pulses
            tx_start_r <= 1'b0;
            pkt_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (pick_found_s) begin
                        grant_valid_r <= 1'b1;
                        grant_idx_r   <= pick_idx_s;
                        count_r       <= '0;
                        state_r       <= (HEADER_EN != 0) ? S_HEADER : S_DATA;
                    end
                end
                S_HEADER: begin
                    if (!tx_busy) begin
                        tx_start_r <= 1'b1;
                        tx_data_r  <= {4'hA, 4'(grant_idx_r)};
                        hdr_r      <= 1'b1;
                        ack_cnt_r  <= '0;
                        state_r    <= S_WAIT_ACK;
                    end
                end
                S_DATA: begin
                    if (xfer_s) begin
                        tx_start_r <= 1'b1;
                        tx_data_r  <= sel_data_s;
                        last_r     <= sel_last_s;
                        hdr_r      <= 1'b0;
                        count_r    <= count_r + 1'b1;
                        ack_cnt_r  <= '0;
                        state_r    <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (tx_busy) begin
                        state_r <= S_WAIT_DONE;
                    end else if (ack_cnt_r == AW'(ACK_TIMEOUT - 1)) begin
                        err_timeout_r <= 1'b1;
                        state_r       <= done_state_s;
                    end else begin
                        ack_cnt_r <= ack_cnt_r + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_r <= done_state_s;
                    end
                end
                S_RELEASE: begin
                    pkt_done_r    <= 1'b1;
                    grant_valid_r <= 1'b0;
                    ptr_r         <= ptr_next_s;
                    count_r       <= '0;
                    hdr_r         <= 1'b0;
                    last_r        <= 1'b0;
                    state_r       <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers, a uart_tx model and
// monitors that pop expected bytes / packet ids whenever the DUT presents them.
module tb_uart_tx_arbiter;
    localparam int NR = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [7:0] gap;
    } entry_t;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            grant_valid;
    logic [3:0]      grant_id;
    logic            pkt_done;
    logic            err_timeout;

    entry_t     rq [NR][$];
    logic [7:0] exp_q[$];
    logic [3:0] exp_pkt_q[$];
    logic       mute;
    int         n_cmp;
    int         n_err;
    int         n_starts;

    uart_tx_arbiter #(
        .NUM_REQ(4), .MAX_BURST(4), .HEADER_EN(1), .ACK_TIMEOUT(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id), .pkt_done(pkt_done),
        .err_timeout(err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input int r, input logic [7:0] d, input logic l, input logic [7:0] g);
        entry_t e;
        e.data = d;
        e.last = l;
        e.gap  = g;
        rq[r].push_back(e);
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < NR; i++) begin
            if (rq[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        while (t < budget && !(rq_empty() && exp_q.size() == 0 && exp_pkt_q.size() == 0
                               && grant_valid == 1'b0)) begin
            @(negedge clk);
            t++;
        end
        check({name, "_complete"}, 32'(t < budget), 32'd1);
    endtask

    task automatic wait_start(input string name, input logic [7:0] d, input int budget);
        int t;
        t = 0;
        while (t < budget && !(tx_start == 1'b1 && tx_data == d)) begin
            @(negedge clk);
            t++;
        end
        check({name, "_seen"}, 32'(t < budget), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'd0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    endtask

    // Requester drivers: present queue heads, pop entries accepted at the previous edge.
    initial begin
        logic [NR-1:0] acc;
        entry_t        e;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        acc       = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
                if (rq[i].size() > 0) begin
                    e = rq[i][0];
                    if (e.gap > 8'd0) begin
                        e.gap    = e.gap - 8'd1;
                        rq[i][0] = e;
                    end else begin
                        req_valid[i]       = 1'b1;
                        req_data[8*i +: 8] = e.data;
                        req_last[i]        = e.last;
                    end
                end
            end
            #1;
            acc = req_valid & req_ready;
        end
    end

    // uart_tx model: busy for four cycles after each start unless muted.
    initial begin
        int busy_cnt;
        tx_busy  = 1'b0;
        busy_cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                tx_busy  = 1'b0;
                busy_cnt = 0;
            end else if (tx_start) begin
                check("start_while_busy", 32'(tx_busy), 32'd0);
                if (!mute) begin
                    tx_busy  = 1'b1;
                    busy_cnt = 4;
                end
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) tx_busy = 1'b0;
            end
        end
    end

    // Monitor: compare every uart byte and every packet release against the scoreboard.
    initial begin
        n_starts = 0;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                check("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
                if (tx_start) begin
                    n_starts++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL tx_byte: got unexpected 0x%0h expected none at %0t", tx_data, $time);
                    end else begin
                        check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
                    end
                end
                if (pkt_done) begin
                    check("pkt_done_grant_valid", 32'(grant_valid), 32'd0);
                    if (exp_pkt_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL pkt_done: got unexpected id %0d expected none at %0t", grant_id, $time);
                    end else begin
                        check("pkt_done_id", 32'(grant_id), 32'(exp_pkt_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_bytes [$];
        int         s;
        n_cmp   = 0;
        n_err   = 0;
        mute    = 1'b0;
        reset_n = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        #2 reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle");

        // Reqs 0 and 3 with two 1-byte packets each, pointer 0: order 0,3,0,3.
        #2;
        add(0, 8'h01, 1'b1, 8'd0); add(0, 8'h02, 1'b1, 8'd0);
        add(3, 8'h31, 1'b1, 8'd0); add(3, 8'h32, 1'b1, 8'd0);
        exp_bytes = '{8'hA0, 8'h01, 8'hA3, 8'h31, 8'hA0, 8'h02, 8'hA3, 8'h32};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd0, 4'd3, 4'd0, 4'd3};
        wait_idle("rr_order", 500);

        // Req 2 three-byte packet with header.
        #2;
        add(2, 8'h11, 1'b0, 8'd0); add(2, 8'h22, 1'b0, 8'd0); add(2, 8'h33, 1'b1, 8'd0);
        exp_bytes = '{8'hA2, 8'h11, 8'h22, 8'h33};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd2};
        wait_idle("basic_pkt", 500);

        // Pointer now 3; req 1 six bytes split by MAX_BURST=4 around reqs 0 and 2.
        #2;
        add(0, 8'h05, 1'b1, 8'd0);
        add(2, 8'h25, 1'b1, 8'd0);
        add(3, 8'h35, 1'b1, 8'd0);
        for (int b = 0; b < 6; b++) add(1, 8'h41 + 8'(b), (b == 5), 8'd0);
        exp_bytes = '{8'hA3, 8'h35, 8'hA0, 8'h05, 8'hA1, 8'h41, 8'h42, 8'h43, 8'h44,
                      8'hA2, 8'h25, 8'hA1, 8'h45, 8'h46};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd3, 4'd0, 4'd1, 4'd2, 4'd1};
        wait_idle("burst_split", 1000);

        // Req 1 stalls 50 cycles mid-packet: grant held, no start meanwhile.
        #2;
        s = n_starts;
        add(1, 8'h51, 1'b0, 8'd0); add(1, 8'h52, 1'b0, 8'd50); add(1, 8'h53, 1'b1, 8'd0);
        exp_bytes = '{8'hA1, 8'h51, 8'h52, 8'h53};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd1};
        repeat (25) @(negedge clk);
        check("stall_grant_valid", 32'(grant_valid), 32'd1);
        check("stall_grant_id", 32'(grant_id), 32'd1);
        check("stall_starts_a", 32'(n_starts - s), 32'd2);
        repeat (25) @(negedge clk);
        check("stall_grant_held", 32'(grant_valid), 32'd1);
        check("stall_starts_b", 32'(n_starts - s), 32'd2);
        wait_idle("stall_resume", 500);

        // Muted uart: timeouts complete the packet and latch err_timeout.
        check("err_before", 32'(err_timeout), 32'd0);
        mute = 1'b1;
        #2;
        add(0, 8'h61, 1'b0, 8'd0); add(0, 8'h62, 1'b1, 8'd0);
        exp_bytes = '{8'hA0, 8'h61, 8'h62};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd0};
        wait_start("timeout_hdr", 8'hA0, 100);
        repeat (4) @(negedge clk);
        check("err_early", 32'(err_timeout), 32'd0);
        repeat (5) @(negedge clk);
        check("err_set", 32'(err_timeout), 32'd1);
        wait_idle("timeout_pkt", 500);
        mute = 1'b0;
        #2;
        add(1, 8'h71, 1'b1, 8'd0);
        exp_q.push_back(8'hA1); exp_q.push_back(8'h71);
        exp_pkt_q.push_back(4'd1);
        wait_idle("after_timeout", 500);
        check("err_sticky", 32'(err_timeout), 32'd1);

        // Reset while waiting for uart_tx to finish a byte.
        #2;
        add(2, 8'h81, 1'b0, 8'd0); add(2, 8'h82, 1'b1, 8'd0);
        exp_bytes = '{8'hA2, 8'h81, 8'h82};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd2};
        wait_start("pre_reset", 8'h81, 200);
        repeat (2) @(negedge clk);
        check("pre_reset_busy", 32'(tx_busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        exp_pkt_q.delete();
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        add(0, 8'h91, 1'b1, 8'd0); add(3, 8'h93, 1'b1, 8'd0);
        exp_bytes = '{8'hA0, 8'h91, 8'hA3, 8'h93};
        foreach (exp_bytes[i]) exp_q.push_back(exp_bytes[i]);
        exp_pkt_q = '{4'd0, 4'd3};
        wait_idle("post_reset", 500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
